// File: rtl/prio_irq_arbiter.sv
// Captures request lines into a pending register and offers one winner (fixed priority or round-robin).
// Latency: request sampled at edge t is pending at t and offered after t+1; the offer holds stable until ready_i claims it.
module prio_irq_arbiter #(
    parameter int N_REQ     = 16,
    parameter int IDX_W     = $clog2(N_REQ),
    parameter bit RR_MODE   = 1'b0,
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] mask_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [N_REQ-1:0] onehot_o,
    output logic [N_REQ-1:0] pending_o,
    output logic             lost_o
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] pending_q;
    logic [N_REQ-1:0] onehot_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] rr_last;
    logic             lost_q;

    logic [N_REQ-1:0] set_vec;
    logic [N_REQ-1:0] clear_vec;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] win_idx;
    logic             claim;
    logic             load;

    assign set_vec   = EDGE_MODE ? (req_i & ~req_q) : req_i;
    assign claim     = (state_q == OFFER) && ready_i;
    assign clear_vec = claim ? onehot_q : '0;
    assign elig      = pending_q & mask_i;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        cand    = elig;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    load    = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                // The offered source is excluded so a claim hands over to the next one without a bubble.
                if (ready_i) begin
                    cand = elig & ~onehot_q;
                    if (|cand) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Rank 0 is searched first; round-robin starts just below the last claimed index and wraps.
    always_comb begin
        int rank;
        int best_rank;
        rank      = 0;
        best_rank = N_REQ;
        win_idx   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            rank = RR_MODE ? (int'(rr_last) - 1 - j) : (N_REQ - 1 - j);
            if (rank < 0) begin
                rank = rank + N_REQ;
            end
            if (cand[j] && (rank < best_rank)) begin
                best_rank = rank;
                win_idx   = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q     <= '0;
            pending_q <= '0;
            onehot_q  <= '0;
            idx_q     <= '0;
            rr_last   <= '0;
            lost_q    <= 1'b0;
        end else begin
            req_q     <= req_i;
            // A new set on a bit being claimed this cycle re-pends it.
            pending_q <= (pending_q & ~clear_vec) | set_vec;
            lost_q    <= EDGE_MODE && (|(set_vec & pending_q & ~clear_vec));
            if (load) begin
                idx_q    <= win_idx;
                onehot_q <= ONE << win_idx;
            end
            if (claim) begin
                rr_last <= idx_q;
            end
        end
    end

    assign valid_o   = (state_q == OFFER);
    assign idx_o     = idx_q;
    assign onehot_o  = valid_o ? onehot_q : '0;
    assign pending_o = pending_q;
    assign lost_o    = lost_q;

endmodule
